ft245_tx_arbiter: RTL and testbench
===================================

FT245_TX_ARBITER -- requirements
Module: ft245_tx_arbiter

Interface
REQ-001 Parameter FLUSH_IDLE, default 64: idle cycles after the last transferred byte before a send-immediate pulse is issued; legal range 2..65535.
REQ-002 Port clock_60mhz  input  1  FT245 synchronous-FIFO clock; the only clock.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port tx_full  input  1  FT245 TXE#; high means the FIFO will not accept a byte at this edge.
REQ-005 Port req0_valid / req0_data[7:0] / req0_ready  in/in/out  1/8/1  requester 0 byte stream (valid/ready).
REQ-006 Port req1_valid / req1_data[7:0] / req1_ready  in/in/out  1/8/1  requester 1 byte stream (valid/ready).
REQ-007 Port data  output  8  FT245 data bus, registered.
REQ-008 Port write_n  output  1  FT245 WR#, registered, active low.
REQ-009 Port read_n, output_enable_n  output  1 each  FT245 RD#, OE#; tied high (TX only).
REQ-010 Port send_immediately_n  output  1  FT245 SIWU#, registered, active low.
REQ-011 Port tx_active_led_n  output  1  low while a byte is presented (equals write_n).
REQ-012 Port power_led_n  output  1  constant high.
REQ-013 Port bytes_sent[15:0]  output  16  count of transferred bytes, wraps 0xFFFF->0x0000.

Function
REQ-014 Transfer: a byte SHALL count as transferred at a rising edge where write_n==0 and tx_full==0; no other condition transfers.
REQ-015 Once presented, data and write_n==0 SHALL be held unchanged until the transferring edge; tx_full high SHALL never drop, duplicate or alter a byte.
REQ-016 Output register "free" = write_n==1 OR a transfer occurs this edge.
REQ-017 reqN_ready SHALL be combinational: high only for the granted requester, only while output register free, only when send_immediately_n is not being asserted next cycle.
REQ-018 Handshake: a byte is taken at an edge where reqN_valid && reqN_ready; it appears on data with write_n==0 from the next cycle (1-cycle latency).
REQ-019 Arbitration: round-robin; pointer last_grant (reset 1, so requester 0 wins first tie); when both valid, grant the one not equal to last_grant; single valid requester always granted; last_grant updates only on a taken byte.
REQ-020 Back-to-back: with a requester continuously valid and tx_full low, write_n SHALL stay low and one byte SHALL transfer every cycle.
REQ-021 If no valid requester when output register frees, write_n SHALL go high next cycle.
REQ-022 FSM states IDLE (write_n=1), SEND (byte presented), FLUSH (SIWU# pulse): IDLE->SEND on take; SEND->SEND on transfer+take or on stall; SEND->IDLE on transfer without take; IDLE->FLUSH when idle_cnt==FLUSH_IDLE-1, dirty==1, tx_full==0; FLUSH->IDLE unconditionally after one cycle.
REQ-023 idle_cnt (16 bit) SHALL clear on every transfer, increment in IDLE, saturate at FLUSH_IDLE-1; dirty set on transfer, cleared on entering FLUSH.
REQ-024 send_immediately_n SHALL be low exactly one cycle, in FLUSH only, with write_n high; no request taken during FLUSH.
REQ-025 If tx_full==1 at the would-be FLUSH edge, remain IDLE with counter saturated; enter FLUSH on first cycle tx_full==0 unless a take occurs that cycle (take wins, dirty kept).
REQ-026 bytes_sent SHALL increment by 1 on each transfer edge, modulo 2^16.
REQ-027 reqN_data SHALL only be sampled at the take edge; changes while not ready are ignored.

Reset
REQ-028 While reset_n low, asynchronously: write_n=1, send_immediately_n=1, read_n=1, output_enable_n=1, power_led_n=1, tx_active_led_n=1, data=0x00, bytes_sent=0, idle_cnt=0, dirty=0, last_grant=1, state IDLE.
REQ-029 Reset mid-transfer SHALL discard the presented byte without counting it; first take allowed on the first edge after reset_n rises.

Verification
REQ-030 req0 streams 0x00..0xFF, tx_full low -> 256 consecutive write_n-low cycles, data increments by 1 each cycle, bytes_sent=256.
REQ-031 tx_full high for 5 cycles while 0x41 presented -> data holds 0x41, write_n low throughout, 0x41 transferred once after release, bytes_sent +1 only.
REQ-032 req0 and req1 both always valid (0xA0, 0xB0) -> accepted order A0,B0,A0,B0..., each requester ready on alternate cycles.
REQ-033 Single byte then idle, FLUSH_IDLE=4 -> send_immediately_n low exactly one cycle, 4 cycles after transfer edge; no second pulse without a new transfer.
REQ-034 reset_n pulsed low while write_n low with data 0x55 -> outputs immediately at reset values, bytes_sent=0, 0x55 never transferred.
REQ-035 bytes_sent preset to 0xFFFF via 65535 transfers then one more -> bytes_sent=0x0000.

Source files
------------

// File: rtl/ft245_tx_arbiter.sv
// FT245 synchronous-FIFO transmit arbiter: merges two valid/ready byte
// streams round-robin onto the FT245 TX bus, with an idle-time SIWU# flush.
//
// Ports:
//   clock_60mhz         FT245 FIFO clock, the only clock
//   reset_n             asynchronous active-low reset
//   tx_full             TXE#, high = FIFO will not accept a byte this edge
//   req0_* / req1_*     requester byte streams (valid/data/ready)
//   data, write_n       registered FT245 data bus and WR#
//   read_n              RD#, tied high (transmit only)
//   output_enable_n     OE#, tied high (transmit only)
//   send_immediately_n  SIWU#, one-cycle registered low pulse
//   tx_active_led_n     mirrors write_n
//   power_led_n         constant high
//   bytes_sent          count of transferred bytes, wraps at 2^16
module ft245_tx_arbiter #(
    parameter int unsigned FLUSH_IDLE = 64
) (
    input  logic       clock_60mhz,
    input  logic       reset_n,
    input  logic       tx_full,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] data,
    output logic       write_n,
    output logic       read_n,
    output logic       output_enable_n,
    output logic       send_immediately_n,
    output logic       tx_active_led_n,
    output logic       power_led_n,
    output logic [15:0] bytes_sent
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [15:0] IDLE_MAX = 16'(FLUSH_IDLE - 1);

    state_t      state;
    logic [15:0] idle_cnt;
    logic        dirty;
    logic        last_grant;

    logic        transfer;
    logic        free;
    logic        grant0;
    logic        grant1;
    logic        flush_now;
    logic        accept_ok;
    logic        take;
    logic [7:0]  take_data;

    assign read_n          = 1'b1;
    assign output_enable_n = 1'b1;
    assign power_led_n     = 1'b1;
    assign tx_active_led_n = write_n;

    always_comb begin
        transfer  = !write_n && !tx_full;
        free      = write_n || transfer;
        grant0    = req0_valid && (!req1_valid || last_grant);
        grant1    = req1_valid && (!req0_valid || !last_grant);
        // A flush is only launched when nobody is asking to send, so a
        // take in the same cycle always wins and dirty is kept.
        flush_now = (state == IDLE) && (idle_cnt == IDLE_MAX) && dirty
                    && !tx_full && !req0_valid && !req1_valid;
        accept_ok = free && (state != FLUSH) && !flush_now;
        req0_ready = grant0 && accept_ok;
        req1_ready = grant1 && accept_ok;
        take      = req0_ready || req1_ready;
        take_data = req1_ready ? req1_data : req0_data;
    end

    always_ff @(posedge clock_60mhz or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            data               <= 8'h00;
            write_n            <= 1'b1;
            send_immediately_n <= 1'b1;
            bytes_sent         <= 16'h0000;
            idle_cnt           <= 16'h0000;
            dirty              <= 1'b0;
            last_grant         <= 1'b1;
        end else begin
            send_immediately_n <= 1'b1;

            if (transfer) begin
                bytes_sent <= bytes_sent + 16'd1;
                dirty      <= 1'b1;
                idle_cnt   <= 16'h0000;
            end else if (state == IDLE && idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 16'd1;
            end

            if (take) begin
                last_grant <= req1_ready;
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        state   <= SEND;
                        data    <= take_data;
                        write_n <= 1'b0;
                    end else if (flush_now) begin
                        state              <= FLUSH;
                        send_immediately_n <= 1'b0;
                        dirty              <= 1'b0;
                    end
                end
                SEND: begin
                    // A take here implies the held byte transfers now.
                    if (take) begin
                        data <= take_data;
                    end else if (transfer) begin
                        state   <= IDLE;
                        write_n <= 1'b1;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    write_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Self-checking bench for ft245_tx_arbiter: scoreboard of expected bytes
// popped on every observed FT245 transfer, plus per-scenario checks.
module tb_ft245_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_full = 1'b0;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_data = 8'h00;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_data = 8'h00;
    logic        req1_ready;
    logic [7:0]  data;
    logic        write_n;
    logic        read_n;
    logic        output_enable_n;
    logic        send_immediately_n;
    logic        tx_active_led_n;
    logic        power_led_n;
    logic [15:0] bytes_sent;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  q[$];
    logic [15:0] exp_sent = 16'h0000;

    always #8 clk = ~clk;

    ft245_tx_arbiter #(.FLUSH_IDLE(4)) dut (
        .clock_60mhz        (clk),
        .reset_n            (reset_n),
        .tx_full            (tx_full),
        .req0_valid         (req0_valid),
        .req0_data          (req0_data),
        .req0_ready         (req0_ready),
        .req1_valid         (req1_valid),
        .req1_data          (req1_data),
        .req1_ready         (req1_ready),
        .data               (data),
        .write_n            (write_n),
        .read_n             (read_n),
        .output_enable_n    (output_enable_n),
        .send_immediately_n (send_immediately_n),
        .tx_active_led_n    (tx_active_led_n),
        .power_led_n        (power_led_n),
        .bytes_sent         (bytes_sent)
    );

    // Transfer monitor: a byte moves at the coming edge when WR# low and
    // TXE# low; inputs are stable between posedge+1 and the next posedge.
    always @(negedge clk) begin
        if (reset_n && !write_n && !tx_full) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL xfer_unexpected: got %h required none", data);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                if (data !== e) begin
                    miscompares++;
                    $display("FAIL xfer_data: got %h required %h", data, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tx_full = 1'b0;
        q.delete();
        exp_sent = 16'h0000;
        idle(2);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic check_sent(input string name);
        @(negedge clk);
        vectors++;
        if (bytes_sent !== exp_sent) begin
            miscompares++;
            $display("FAIL %s: bytes_sent got %h required %h",
                     name, bytes_sent, exp_sent);
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: queue left %0d required 0", name, q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, output int low_cnt, output int bad_rdy);
        low_cnt = 0;
        bad_rdy = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            req0_data = i[7:0];
            @(negedge clk);
            if (!write_n) low_cnt++;
            if (req0_ready !== 1'b1) bad_rdy++;
            q.push_back(i[7:0]);
            exp_sent = exp_sent + 16'd1;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!write_n) low_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({write_n, send_immediately_n, read_n, output_enable_n,
             power_led_n, tx_active_led_n, data, bytes_sent}
            !== {6'b111111, 8'h00, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b%b%b%b%b%b %h %h required 111111 00 0000",
                     write_n, send_immediately_n, read_n, output_enable_n,
                     power_led_n, tx_active_led_n, data, bytes_sent);
        end
        reset_n = 1'b1;
        idle(2);
        vectors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: got %b%b required 00", req0_ready, req1_ready);
        end
    endtask

    task automatic test_stream();
        int low_cnt;
        int bad_rdy;
        stream(256, low_cnt, bad_rdy);
        vectors++;
        if (low_cnt != 256) begin
            miscompares++;
            $display("FAIL stream_wr_low: got %0d cycles required 256", low_cnt);
        end
        vectors++;
        if (bad_rdy != 0) begin
            miscompares++;
            $display("FAIL stream_ready: got %0d not-ready cycles required 0", bad_rdy);
        end
        check_sent("stream_count");
        idle(10);
    endtask

    task automatic test_stall();
        int bad = 0;
        int bad_rdy = 0;
        @(posedge clk); #1;
        tx_full = 1'b1;
        req0_valid = 1'b1;
        req0_data = 8'h41;
        @(negedge clk);
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_take_ready: got %b required 1", req0_ready);
        end
        q.push_back(8'h41);
        exp_sent = exp_sent + 16'd1;
        @(posedge clk); #1;
        req0_data = 8'h99;
        repeat (5) begin
            @(negedge clk);
            if (write_n !== 1'b0 || data !== 8'h41) bad++;
            if (req0_ready !== 1'b0) bad_rdy++;
            @(posedge clk); #1;
        end
        tx_full = 1'b0;
        req0_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_hold: got %0d bad cycles required 0", bad);
        end
        vectors++;
        if (bad_rdy != 0) begin
            miscompares++;
            $display("FAIL stall_ready: got %0d ready cycles required 0", bad_rdy);
        end
        idle(3);
        check_sent("stall_count");
        idle(10);
    endtask

    task automatic test_round_robin();
        int bad = 0;
        do_reset();
        req0_valid = 1'b1;
        req0_data = 8'hA0;
        req1_valid = 1'b1;
        req1_data = 8'hB0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) bad++;
            q.push_back((k % 2 == 0) ? 8'hA0 : 8'hB0);
            exp_sent = exp_sent + 16'd1;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rr_ready: got %0d wrong cycles required 0", bad);
        end
        idle(3);
        check_sent("rr_count");
    endtask

    task automatic send_one(input logic [7:0] b);
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req0_data = b;
        @(negedge clk);
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: got %b required 1", req0_ready);
        end
        q.push_back(b);
        exp_sent = exp_sent + 16'd1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [19:0] mask = '0;
        int bad = 0;
        do_reset();
        send_one(8'h3C);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!send_immediately_n) begin
                mask[i] = 1'b1;
                if (!write_n) bad++;
            end
        end
        vectors++;
        if (mask !== 20'h00010) begin
            miscompares++;
            $display("FAIL flush_pulse: got mask %h required 00010", mask);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL flush_wr: got %0d pulses with WR# low required 0", bad);
        end
        @(posedge clk); #1;
        check_sent("flush_count");
    endtask

    task automatic test_flush_blocked();
        logic [7:0] m1 = '0;
        logic [3:0] m2 = '0;
        send_one(8'h5A);
        @(posedge clk); #1;
        tx_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!send_immediately_n) m1[i] = 1'b1;
        end
        @(posedge clk); #1;
        tx_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!send_immediately_n) m2[i] = 1'b1;
        end
        vectors++;
        if (m1 !== 8'h00) begin
            miscompares++;
            $display("FAIL flush_blocked: got mask %h required 00", m1);
        end
        vectors++;
        if (m2 !== 4'b0010) begin
            miscompares++;
            $display("FAIL flush_release: got mask %b required 0010", m2);
        end
        @(posedge clk); #1;
        check_sent("flush_blk_count");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        tx_full = 1'b1;
        req0_valid = 1'b1;
        req0_data = 8'h55;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (write_n !== 1'b0 || data !== 8'h55) begin
            miscompares++;
            $display("FAIL mid_present: got %b %h required 0 55", write_n, data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({write_n, send_immediately_n, tx_active_led_n, data, bytes_sent}
            !== {3'b111, 8'h00, 16'h0000}) begin
            miscompares++;
            $display("FAIL mid_async_reset: got %b%b%b %h %h required 111 00 0000",
                     write_n, send_immediately_n, tx_active_led_n, data, bytes_sent);
        end
        q.delete();
        exp_sent = 16'h0000;
        tx_full = 1'b0;
        idle(2);
        reset_n = 1'b1;
        req0_valid = 1'b1;
        req0_data = 8'h66;
        @(negedge clk);
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_ready: got %b required 1", req0_ready);
        end
        q.push_back(8'h66);
        exp_sent = exp_sent + 16'd1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        idle(3);
        check_sent("mid_count");
        idle(10);
    endtask

    task automatic test_wrap();
        int low_cnt;
        int bad_rdy;
        do_reset();
        stream(65535, low_cnt, bad_rdy);
        vectors++;
        if (bad_rdy != 0) begin
            miscompares++;
            $display("FAIL wrap_ready: got %0d not-ready cycles required 0", bad_rdy);
        end
        check_sent("wrap_ffff");
        idle(10);
        stream(1, low_cnt, bad_rdy);
        check_sent("wrap_zero");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_round_robin();
        test_flush();
        test_flush_blocked();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
